// File: rtl/led_pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM LED driver.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_t;

  // Clock cycles per PWM slot; never below one so the phase always advances.
  function automatic int slot_div(input int clk_freq, input int pwm_freq, input int duty_w);
    int d;
    d = clk_freq / (pwm_freq * (1 << duty_w));
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One PWM channel: shadow/active config, blink counter, breathe FSM, optional gamma (LED_PWM_GAMMA_EN), registered compare.
// Latency: pwm is one cycle behind phase; config changes take effect at the next period boundary.
// Backpressure: none; a write is accepted on any cycle.
module led_pwm_chan
  import led_pwm_pkg::*;
#(
  parameter int DUTY_W        = 8,
  parameter int BLINK_PERIODS = 2500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boundary,
  input  logic [DUTY_W-1:0] phase,
  input  logic              wr_en,
  input  logic [1:0]        wr_mode,
  input  logic [DUTY_W-1:0] wr_duty,
  input  logic              ch_en,
  output logic              pwm
);

  localparam int BC_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  mode_t             sh_mode, act_mode, nxt_mode;
  logic [DUTY_W-1:0] sh_duty, act_duty, nxt_duty;
  logic [DUTY_W-1:0] level, lvl_eff, lvl_cmp;
  breathe_dir_t      dir;
  logic              blink_on;
  logic [BC_W-1:0]   blink_cnt;

  // A write landing in the boundary cycle goes straight into the active register.
  assign nxt_mode = wr_en ? mode_t'(wr_mode) : sh_mode;
  assign nxt_duty = wr_en ? wr_duty : sh_duty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_mode <= MODE_OFF;
      sh_duty <= '0;
    end else if (wr_en) begin
      sh_mode <= mode_t'(wr_mode);
      sh_duty <= wr_duty;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_mode  <= MODE_OFF;
      act_duty  <= '0;
      level     <= '0;
      dir       <= DIR_UP;
      blink_on  <= 1'b1;
      blink_cnt <= '0;
    end else if (boundary) begin
      act_mode <= nxt_mode;
      act_duty <= nxt_duty;
      if (nxt_mode != act_mode) begin
        level     <= '0;
        dir       <= DIR_UP;
        blink_on  <= 1'b1;
        blink_cnt <= '0;
      end else if (act_mode == MODE_BLINK) begin
        if (blink_cnt == BC_W'(BLINK_PERIODS - 1)) begin
          blink_cnt <= '0;
          blink_on  <= !blink_on;
        end else begin
          blink_cnt <= blink_cnt + BC_W'(1);
        end
      end else if (act_mode == MODE_BREATHE) begin
        if (nxt_duty == '0) begin
          level <= '0;
          dir   <= DIR_UP;
        end else if (level > nxt_duty) begin
          level <= nxt_duty;
          dir   <= DIR_DOWN;
        end else if (dir == DIR_UP) begin
          if (level == nxt_duty) begin
            level <= level - DUTY_W'(1);
            dir   <= DIR_DOWN;
          end else begin
            level <= level + DUTY_W'(1);
            if (level == nxt_duty - DUTY_W'(1)) dir <= DIR_DOWN;
          end
        end else begin
          if (level == '0) begin
            level <= DUTY_W'(1);
            dir   <= DIR_UP;
          end else begin
            level <= level - DUTY_W'(1);
            if (level == DUTY_W'(1)) dir <= DIR_UP;
          end
        end
      end
    end
  end

  always_comb begin
    lvl_eff = '0;
    case (act_mode)
      MODE_STATIC:  lvl_eff = act_duty;
      MODE_BLINK:   lvl_eff = blink_on ? act_duty : '0;
      MODE_BREATHE: lvl_eff = level;
      default:      lvl_eff = '0;
    endcase
  end

`ifdef LED_PWM_GAMMA_EN
  logic [2*DUTY_W-1:0] lvl_sq;
  assign lvl_sq  = {{DUTY_W{1'b0}}, lvl_eff} * {{DUTY_W{1'b0}}, lvl_eff};
  assign lvl_cmp = lvl_sq[2*DUTY_W-1:DUTY_W];
`else
  assign lvl_cmp = lvl_eff;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm <= 1'b0;
    else      pwm <= ch_en && (phase < lvl_cmp);
  end

endmodule

// File: rtl/led_pwm_array.sv
// NUM_CH-channel PWM LED driver on a shared prescaler/phase counter; LED_PWM_GAMMA_EN enables gamma-squared levels.
// Latency: o_pwm registered one cycle after phase; config applies at the next period boundary.
// Backpressure: none; the write port takes one write per asserted cycle, out-of-range channels dropped.
module led_pwm_array
  import led_pwm_pkg::*;
#(
  parameter int CLK_FREQ      = 12000000,
  parameter int PWM_FREQ      = 5000,
  parameter int NUM_CH        = 6,
  parameter int DUTY_W        = 8,
  parameter int BLINK_PERIODS = 2500,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [1:0]        i_wr_mode,
  input  logic [DUTY_W-1:0] i_wr_duty,
  input  logic [NUM_CH-1:0] i_ch_en,
  output logic [NUM_CH-1:0] o_pwm,
  output logic              o_period_tick
);

  localparam int SLOT_DIV = slot_div(CLK_FREQ, PWM_FREQ, DUTY_W);
  localparam int PRE_W    = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;

  logic [PRE_W-1:0]  pre_cnt;
  logic [DUTY_W-1:0] phase;
  logic              pre_wrap, boundary;

  assign pre_wrap = (pre_cnt == PRE_W'(SLOT_DIV - 1));
  assign boundary = pre_wrap && (phase == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt       <= '0;
      phase         <= '0;
      o_period_tick <= 1'b0;
    end else begin
      pre_cnt       <= pre_wrap ? '0 : pre_cnt + PRE_W'(1);
      if (pre_wrap) phase <= phase + DUTY_W'(1);
      o_period_tick <= boundary;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic wr_hit;
    // No channel index aliases an out-of-range i_wr_ch, so those writes match nothing.
    assign wr_hit = i_wr_en && (i_wr_ch == CH_W'(ch));

    led_pwm_chan #(
      .DUTY_W        (DUTY_W),
      .BLINK_PERIODS (BLINK_PERIODS)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .boundary (boundary),
      .phase    (phase),
      .wr_en    (wr_hit),
      .wr_mode  (i_wr_mode),
      .wr_duty  (i_wr_duty),
      .ch_en    (i_ch_en[ch]),
      .pwm      (o_pwm[ch])
    );
  end

endmodule
